// File: rtl/abs_datapath_if.sv
// Command/status bundle between the load/select controller and abs_datapath.
// The controller side is master; the datapath side is slave.
interface abs_datapath_if #(
    parameter int WIDTH = 8
);
    logic             L;
    logic             S;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] R;
    logic             R7;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             ovf;
    logic             err;
    logic [7:0]       count;

    modport master (
        output L, S, din,
        input  R, R7, result, done, ovf, err, count
    );

    modport slave (
        input  L, S, din,
        output R, R7, result, done, ovf, err, count
    );
endinterface

// File: rtl/abs_datapath.sv
// Absolute-value datapath: working register, load/negate commands,
// phase tracking for completion, overflow and protocol-error detection.
module abs_datapath #(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    abs_datapath_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        NEG
    } phase_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    phase_t           phase;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] res;
    logic             done_q;
    logic             ovf_q;
    logic             err_q;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] neg;
    logic             r_min;

    assign neg   = ~r + ONE;
    assign r_min = (r == MIN);

    assign bus.R      = r;
    assign bus.R7     = r[WIDTH-1];
    assign bus.result = res;
    assign bus.done   = done_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;
    assign bus.count  = cnt;

    // S is only looked at under L, so an undriven S while idle never lands in state.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= IDLE;
            r      <= '0;
            res    <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt    <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.L) begin
                if (bus.S) begin
                    r     <= bus.din;
                    ovf_q <= 1'b0;
                end else begin
                    r <= neg;
                end
            end
            case (phase)
                IDLE: begin
                    if (bus.L) begin
                        if (bus.S) begin
                            phase <= CHECK;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (!bus.L) begin
                        if (!r[WIDTH-1]) begin
                            res    <= r;
                            done_q <= 1'b1;
                            cnt    <= cnt + 8'd1;
                            phase  <= IDLE;
                        end else begin
                            phase <= NEG;
                        end
                    end else if (bus.S) begin
                        err_q <= 1'b1;
                    end else begin
                        err_q  <= 1'b1;
                        res    <= neg;
                        ovf_q  <= r_min;
                        done_q <= 1'b1;
                        cnt    <= cnt + 8'd1;
                        phase  <= IDLE;
                    end
                end
                NEG: begin
                    if (bus.L) begin
                        if (bus.S) begin
                            err_q <= 1'b1;
                            phase <= CHECK;
                        end else begin
                            res    <= neg;
                            ovf_q  <= r_min;
                            done_q <= 1'b1;
                            cnt    <= cnt + 8'd1;
                            phase  <= IDLE;
                        end
                    end
                end
                default: phase <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/abs_datapath.md
# abs_datapath

Datapath stage paired with the load/select control FSM: it owns the working register whose MSB is returned to the controller as `R7`, and it executes the controller's `L`/`S` commands. The pair computes the absolute value of a signed operand: load it, test its sign, conditionally negate it, and publish the result with a one-cycle `done` pulse. The block also tracks the command sequence so that it can detect completion, arithmetic overflow and out-of-sequence commands without any extra controller outputs.

## Interface
- `WIDTH`, default 8: operand/register width in bits, two's complement.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `L`  in  1  load enable from controller.
- `S`  in  1  source select: 1 = `din`, 0 = negate `R`; don't-care (may be X) when `L`=0.
- `din`  in  WIDTH  signed operand, sampled only on a load with `S`=1.
- `R`  out  WIDTH  working register.
- `R7`  out  1  `R[WIDTH-1]`, combinational from the register, sign flag to controller.
- `result`  out  WIDTH  last completed absolute value, held between operations.
- `done`  out  1  one-cycle completion pulse.
- `ovf`  out  1  last operation negated the most-negative value.
- `err`  out  1  sticky protocol-error flag.
- `count`  out  8  completed operations, wraps modulo 256.

## Operation
- Reset: `R`=0, `R7`=0, `result`=0, `done`=0, `ovf`=0, `err`=0, `count`=0, phase=IDLE. Reset overrides every input in the same cycle.
- `S` is never evaluated when `L`=0. X on `S` with `L`=0 must not propagate into any state.
- Register update: `L`=1,`S`=1 → `R`<=`din`. `L`=1,`S`=0 → `R`<=(~`R`)+1, truncated to WIDTH. `L`=0 → hold.
- Phase FSM (IDLE, CHECK, NEG):
  - IDLE, `L`=1,`S`=1: load. `ovf`<=0. Go to CHECK.
  - IDLE, `L`=1,`S`=0: negate `R`. `err`<=1. Phase stays IDLE. No `done`.
  - IDLE, `L`=0: hold.
  - CHECK, `L`=0, `R7`=0: complete with `result`<=`R`. Go to IDLE.
  - CHECK, `L`=0, `R7`=1: go to NEG.
  - CHECK, `L`=1,`S`=1: reload. `err`<=1. Stay in CHECK.
  - CHECK, `L`=1,`S`=0: negate and complete. `err`<=1. Go to IDLE.
  - NEG, `L`=1,`S`=0: negate and complete with `result`<=(~`R`)+1. Go to IDLE.
  - NEG, `L`=0: hold in NEG.
  - NEG, `L`=1,`S`=1: reload. `err`<=1. Go to CHECK.
- Completion, at the completing edge: `result` is updated, `done`<=1 for exactly one cycle, `count`<=`count`+1 (255→0).
- `ovf`: set on a completing negation when the pre-negation `R` = 1 followed by WIDTH-1 zeros (0x80 for WIDTH=8). The result then equals that same value. `ovf` holds until the next load.
- `err`: set by any out-of-sequence command listed above. Cleared only by reset.

## Timing
- Load to `R`/`R7` valid: 1 cycle after the edge that samples `L`=1,`S`=1.
- Positive operand: load edge, then completion at the next edge (CHECK cycle). `done` is high during cycle 2 after the load cycle.
- Negative operand: load edge, CHECK edge, then negate edge. `done` is high during the cycle after the negate edge.
- `result` changes only on the completing edge, simultaneously with `done` rising. It is stable at all other times.
- `R7` is combinational from `R`. There is no added latency into the controller's next-state logic.
- Back-to-back: a load in the cycle `done` is high is legal. It is handled from IDLE normally.
- Reset asserted mid-operation (CHECK or NEG): the next cycle is in reset state with no `done` and no `count` increment.

## Test plan
- `din`=0x35, L/S sequence 11,0x → `R`=0x35, `R7`=0 in CHECK; `done` pulse with `result`=0x35, `ovf`=0, `count`=1, `err`=0.
- `din`=0xF6, sequence 11,0x,10 → `R7`=1 in CHECK; `R`=0x0A after negate; `done` with `result`=0x0A, `count` increments, `ovf`=0.
- `din`=0x80, sequence 11,0x,10 → `result`=0x80, `ovf`=1. A following load of 0x01 clears `ovf`.
- Load 0xF6, then assert reset during CHECK → all outputs zero next cycle, no `done`. Re-run with 0x05 → `result`=0x05.
- From IDLE with `R`=0x03, drive `L`=1,`S`=0 → `R`=0xFD, `err`=1 (sticky across later normal ops), no `done`. Also drive `S`=X with `L`=0 → no state change.
- 256 consecutive positive operations → `count` wraps to 0, and a `done` pulse accompanies each operation.
